bkm_e_iter_csd: RTL and testbench
=================================

Name: bkm_e_iter_csd

Overview:
- Sequential BKM E-mode iteration engine for the xfire FPU BKM datapath.
- Holds the complex CSD accumulator E and computes E(n+1) = E(n) + d(n)·E(n)·2^-n for n = 0..N_ITER-1.
- Each iteration is split into two passes through one complex_add_subb_csd instance.
- Digits d(n) = dx + i·dy arrive from the upstream digit-selection stage over a valid/ready handshake; the converged E goes downstream with a done pulse.

Parameters:
- W, 8, number of CSD digits per component; each component bus is 2W bits.
- N_ITER, 8, number of BKM iterations; legal range 1..W.
- CNT_W, $clog2(N_ITER+1), width of the iteration counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  load e0 and begin; accepted only when ready=1.
- ready  out  1  high in IDLE.
- e0_x  in  2W  initial real part, CSD.
- e0_y  in  2W  initial imaginary part, CSD.
- d_valid  in  1  digit pair valid.
- d_ready  out  1  high in PH_A; transfer = d_valid & d_ready.
- d_x  in  2  real digit: 01=+1, 11=-1, 00=0, 10=illegal (treated as 0).
- d_y  in  2  imaginary digit, same encoding as d_x.
- e_x  out  2W  accumulator real part, CSD.
- e_y  out  2W  accumulator imaginary part, CSD.
- done  out  1  one-cycle pulse; e_x/e_y are final.
- ovf  out  1  sticky; set when an adder carry digit is nonzero.

Behaviour:
- CSD digit encoding {pos,neg}: 00=0, 10=+1, 01=-1; 11 is never produced.
- S = E >> n: drop the low n digit pairs, fill the top with 00. This is an exact CSD truncation and needs no sign fill.
- FSM states: IDLE, PH_A, PH_B, DONE.
- IDLE, start=1: E <= e0; n <= 0; ovf <= 0; go to PH_A. start in any other state is ignored.
- PH_A, waiting: d_ready=1. If d_valid=0, stall with all registers held.
- PH_A, on transfer: latch dx and dy; T <= E + dx·S. Adder inputs a=E, b=(Sx,Sy), subb_b_x = subb_b_y = (dx==-1). If dx=0, b is forced to all 00. Go to PH_B.
- PH_B: E <= (Tx - dy·Sy, Ty + dy·Sx). Adder inputs a=T, b=(Sy,Sx); subb_b_x=(dy==+1), subb_b_y=(dy==-1). If dy=0, b is forced to 00.
- PH_B exit: if n==N_ITER-1, go to DONE; otherwise n <= n+1 and go to PH_A.
- DONE: done=1 for one cycle, then IDLE. e_x/e_y hold their value until the next accepted start.
- Width rule: adder output is W+1 digits. Keep the low W digits. If the carry digit is nonzero in either component, set ovf.
- Latency: with d_valid held high, start accepted at cycle 0 gives done at cycle 2·N_ITER+1.
- Reset values: state=IDLE, E=0, T=0, n=0, ready=1, d_ready=0, done=0, ovf=0.
- rst mid-operation aborts the computation; no done pulse is produced.

Optional Feature:
- Macro BKM_E_ITER_SKIP_ZERO_EN.
- Defined: in PH_A, if the latched dy==0, write E <= T directly and skip PH_B. The n-increment and exit logic move into PH_A, so the iteration costs one cycle.
- Undefined: every iteration takes exactly two cycles, so latency is deterministic.
- Results are identical in both builds.

Decomposition:
- Shared package bkm_csd_pkg holds:
  - CSD digit constants CSD_ZERO, CSD_POS, CSD_NEG.
  - Digit constants D_ZERO, D_POS, D_NEG.
  - FSM state localparams.
- Sub-module: one complex_add_subb_csd #(W), time-shared between PH_A and PH_B. Its operand muxes and subb select live in this block.

Test Plan (W=8, N_ITER=3 unless stated):
- All digits 0, e0=(16,0) -> e=(16,0), done at cycle 7, ovf=0.
- dx=+1 and dy=0 every iteration, e0=(16,0) -> E = 32, 48, 60; final e=(60,0), ovf=0.
- N_ITER=2, e0=(16,0), digits (0,+1) then (0,-1) -> E after n0 = (16,16); final e=(24,8).
- d_valid low for 5 cycles in PH_A of n1 -> registers frozen; done delayed exactly 5 cycles; values match the no-stall run.
- e0=(192,0), dx=+1 at n0 -> carry detected, ovf=1 until the next start; start while busy is ignored.
- rst asserted during PH_B of n1 -> next cycle ready=1, e=0, ovf=0, no done. With BKM_E_ITER_SKIP_ZERO_EN, the dy=0 case gives done at cycle 4.

Source files
------------

// File: rtl/bkm_csd_pkg.sv
// +----------------------------------------------------------------------+
// | bkm_csd_pkg                                                          |
// | Shared CSD/digit encodings and BKM E-iteration FSM state codes.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bkm_csd_pkg;

    // Accumulator digit encoding {pos,neg}
    localparam logic [1:0] CSD_ZERO = 2'b00;
    localparam logic [1:0] CSD_POS  = 2'b10;
    localparam logic [1:0] CSD_NEG  = 2'b01;

    // Upstream selection digit encoding (two's complement, 10 reads as zero)
    localparam logic [1:0] D_ZERO   = 2'b00;
    localparam logic [1:0] D_POS    = 2'b01;
    localparam logic [1:0] D_NEG    = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PH_A  = 2'd1;
    localparam logic [1:0] ST_PH_B  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/complex_add_subb_csd.sv
// +----------------------------------------------------------------------+
// | complex_add_subb_csd                                                 |
// | Per-component a +/- b on W-digit signed-digit operands, W+1 digits   |
// | out in sign-magnitude form (every nonzero digit carries the sign).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module complex_add_subb_csd
    import bkm_csd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2*W-1:0] a_x,
    input  logic [2*W-1:0] a_y,
    input  logic [2*W-1:0] b_x,
    input  logic [2*W-1:0] b_y,
    input  logic           subb_b_x,
    input  logic           subb_b_y,
    output logic [2*W+1:0] s_x,
    output logic [2*W+1:0] s_y
);

    // |a +/- b| <= 2^(W+1)-2, so W+1 magnitude digits always suffice.
    function automatic logic [2*W+1:0] f_addsub(
        input logic [2*W-1:0] a,
        input logic [2*W-1:0] b,
        input logic           sub
    );
        logic [W-1:0]        ap, an, bp, bn;
        logic signed [W+1:0] av, bv, sum;
        logic [W:0]          mag;
        logic [2*W+1:0]      res;
        for (int i = 0; i < W; i++) begin
            ap[i] = a[2*i+1];
            an[i] = a[2*i];
            bp[i] = b[2*i+1];
            bn[i] = b[2*i];
        end
        av  = $signed({2'b00, ap}) - $signed({2'b00, an});
        bv  = $signed({2'b00, bp}) - $signed({2'b00, bn});
        sum = sub ? (av - bv) : (av + bv);
        mag = sum[W+1] ? (~sum[W:0] + 1'b1) : sum[W:0];
        res = '0;
        for (int i = 0; i <= W; i++) begin
            if (mag[i]) begin
                res[2*i+:2] = sum[W+1] ? CSD_NEG : CSD_POS;
            end else begin
                res[2*i+:2] = CSD_ZERO;
            end
        end
        return res;
    endfunction

    assign s_x = f_addsub(a_x, b_x, subb_b_x);
    assign s_y = f_addsub(a_y, b_y, subb_b_y);

endmodule

`default_nettype wire

// File: rtl/bkm_e_iter_csd.sv
// +----------------------------------------------------------------------+
// | bkm_e_iter_csd                                                       |
// | Sequential BKM E-mode engine: E += d(n)*E*2^-n, two adder passes per |
// | iteration. Option macro: BKM_E_ITER_SKIP_ZERO_EN (skip PH_B if dy=0).|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bkm_e_iter_csd
    import bkm_csd_pkg::*;
#(
    parameter int W      = 8,
    parameter int N_ITER = 8,
    parameter int CNT_W  = $clog2(N_ITER + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           ready,
    input  logic [2*W-1:0] e0_x,
    input  logic [2*W-1:0] e0_y,
    input  logic           d_valid,
    output logic           d_ready,
    input  logic [1:0]     d_x,
    input  logic [1:0]     d_y,
    output logic [2*W-1:0] e_x,
    output logic [2*W-1:0] e_y,
    output logic           done,
    output logic           ovf
);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(N_ITER - 1);

    logic [1:0]       r_state;
    logic [2*W-1:0]   r_ex, r_ey, r_tx, r_ty;
    logic [CNT_W-1:0] r_n;
    logic [1:0]       r_dy;
    logic             r_ovf;

    logic [2*W-1:0]   w_sx, w_sy;
    logic [2*W-1:0]   w_a_x, w_a_y, w_b_x, w_b_y;
    logic             w_subb_x, w_subb_y;
    logic [2*W+1:0]   w_s_x, w_s_y;
    logic             w_dx_nz, w_dy_nz, w_carry, w_last;

    // Dropping n low digit pairs is an exact truncation of a signed-digit word.
    assign w_sx    = r_ex >> {r_n, 1'b0};
    assign w_sy    = r_ey >> {r_n, 1'b0};
    assign w_dx_nz = (d_x == D_POS) || (d_x == D_NEG);
    assign w_dy_nz = (r_dy == D_POS) || (r_dy == D_NEG);
    assign w_last  = (r_n == c_last_iter);
    assign w_carry = (|w_s_x[2*W+:2]) | (|w_s_y[2*W+:2]);

    always_comb begin
        w_a_x    = r_ex;
        w_a_y    = r_ey;
        w_b_x    = w_dx_nz ? w_sx : '0;
        w_b_y    = w_dx_nz ? w_sy : '0;
        w_subb_x = (d_x == D_NEG);
        w_subb_y = (d_x == D_NEG);
        if (r_state == ST_PH_B) begin
            // i*dy*S swaps the components: x gets -dy*Sy, y gets +dy*Sx
            w_a_x    = r_tx;
            w_a_y    = r_ty;
            w_b_x    = w_dy_nz ? w_sy : '0;
            w_b_y    = w_dy_nz ? w_sx : '0;
            w_subb_x = (r_dy == D_POS);
            w_subb_y = (r_dy == D_NEG);
        end
    end

    complex_add_subb_csd #(.W(W)) u_add (
        .a_x      (w_a_x),
        .a_y      (w_a_y),
        .b_x      (w_b_x),
        .b_y      (w_b_y),
        .subb_b_x (w_subb_x),
        .subb_b_y (w_subb_y),
        .s_x      (w_s_x),
        .s_y      (w_s_y)
    );

`ifdef BKM_E_ITER_SKIP_ZERO_EN
    logic w_dy_in_nz;
    assign w_dy_in_nz = (d_y == D_POS) || (d_y == D_NEG);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ex    <= '0;
            r_ey    <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_n     <= '0;
            r_dy    <= D_ZERO;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ex    <= e0_x;
                        r_ey    <= e0_y;
                        r_n     <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_PH_A;
                    end
                end
                ST_PH_A: begin
                    if (d_valid) begin
                        r_dy  <= d_y;
                        r_tx  <= w_s_x[2*W-1:0];
                        r_ty  <= w_s_y[2*W-1:0];
                        r_ovf <= r_ovf | w_carry;
`ifdef BKM_E_ITER_SKIP_ZERO_EN
                        if (!w_dy_in_nz) begin
                            r_ex <= w_s_x[2*W-1:0];
                            r_ey <= w_s_y[2*W-1:0];
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_n     <= r_n + 1'b1;
                                r_state <= ST_PH_A;
                            end
                        end else begin
                            r_state <= ST_PH_B;
                        end
`else
                        r_state <= ST_PH_B;
`endif
                    end
                end
                ST_PH_B: begin
                    r_ex  <= w_s_x[2*W-1:0];
                    r_ey  <= w_s_y[2*W-1:0];
                    r_ovf <= r_ovf | w_carry;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_n     <= r_n + 1'b1;
                        r_state <= ST_PH_A;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = (r_state == ST_IDLE);
    assign d_ready = (r_state == ST_PH_A);
    assign done    = (r_state == ST_DONE);
    assign e_x     = r_ex;
    assign e_y     = r_ey;
    assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bkm_e_iter_csd.sv
// +----------------------------------------------------------------------+
// | tb_bkm_e_iter_csd                                                    |
// | Self-checking bench for bkm_e_iter_csd (W=8, N_ITER=3).              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bkm_e_iter_csd;

    localparam int W = 8;
    localparam int N = 3;
`ifdef BKM_E_ITER_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [15:0]   e0_x = '0;
    logic [15:0]   e0_y = '0;
    logic          d_valid = 1'b0;
    logic          d_ready;
    logic [1:0]    d_x = 2'b00;
    logic [1:0]    d_y = 2'b00;
    logic [15:0]   e_x, e_y;
    logic          done, ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] dx_q [N];
    logic [1:0] dy_q [N];
    int         obs_ex [N];
    int         obs_ey [N];

    always #5 clk = ~clk;

    bkm_e_iter_csd #(.W(W), .N_ITER(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ready   (ready),
        .e0_x    (e0_x),
        .e0_y    (e0_y),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_x     (d_x),
        .d_y     (d_y),
        .e_x     (e_x),
        .e_y     (e_y),
        .done    (done),
        .ovf     (ovf)
    );

    // ---------------- reference model: plain integer arithmetic ----------------
    function automatic int val(input logic [15:0] b);
        int v = 0;
        for (int i = 0; i < W; i++) begin
            if (b[2*i+1]) v += (1 << i);
            if (b[2*i])   v -= (1 << i);
        end
        return v;
    endfunction

    function automatic logic [15:0] enc(input int v);
        logic [15:0] b = '0;
        int m = (v < 0) ? -v : v;
        for (int i = 0; i < W; i++) begin
            if ((m >> i) & 1) begin
                if (v > 0) b[2*i+1] = 1'b1;
                else       b[2*i]   = 1'b1;
            end
        end
        return b;
    endfunction

    function automatic logic [15:0] rand_csd();
        logic [15:0] b = '0;
        for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 2))
                0:       b[2*i+:2] = 2'b00;
                1:       b[2*i+:2] = 2'b10;
                default: b[2*i+:2] = 2'b01;
            endcase
        end
        return b;
    endfunction

    function automatic int dig(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    // Shifting a sign-magnitude word right truncates toward zero.
    function automatic int trunc(input int v, input int n);
        return (v >= 0) ? (v >> n) : -((-v) >> n);
    endfunction

    function automatic bool_t_dummy_unused; return 0; endfunction

    function automatic int keep(input int v);
        int m = (v < 0) ? -v : v;
        m = m % 256;
        return (v < 0) ? -m : m;
    endfunction

    function automatic bit big(input int v);
        return (v >= 256) || (v <= -256);
    endfunction

    function automatic void model(input int ix, input int iy, output int ox, output int oy,
                                  output bit oovf, output int olat);
        int x = ix, y = iy, tx, ty, sx, sy, a, b;
        oovf = 1'b0;
        olat = 1;
        for (int n = 0; n < N; n++) begin
            a  = dig(dx_q[n]);
            b  = dig(dy_q[n]);
            sx = trunc(x, n);
            sy = trunc(y, n);
            if (big(x + a*sx) || big(y + a*sy)) oovf = 1'b1;
            tx = keep(x + a*sx);
            ty = keep(y + a*sy);
            if (big(tx - b*sy) || big(ty + b*sx)) oovf = 1'b1;
            x  = keep(tx - b*sy);
            y  = keep(ty + b*sx);
            olat += (SKIP && b == 0) ? 1 : 2;
        end
        ox = x;
        oy = y;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [15:0] ix, input logic [15:0] iy,
                          input int stall_iter, input int stall_len, input bit busy_start,
                          output logic [15:0] ox, output logic [15:0] oy, output logic oovf,
                          output int lat, output bit frozen_ok, output bit pulse_ok,
                          output bit timeout);
        int          iter = 0;
        int          stall_left = stall_len;
        bit          stalling = 1'b0;
        logic [15:0] fx = '0, fy = '0;
        int          k = 0;
        timeout = 1'b0; frozen_ok = 1'b1; pulse_ok = 1'b1; lat = -1;
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready) timeout = 1'b1;
        start = 1'b1; e0_x = ix; e0_y = iy;
        d_valid = 1'b1; d_x = 2'($urandom); d_y = 2'($urandom);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (busy_start) begin
                e0_x = 16'($urandom); e0_y = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (stalling && (e_x !== fx || e_y !== fy)) frozen_ok = 1'b0;
            if (done) begin
                lat = cyc;
                break;
            end
            if (d_ready) begin
                if (iter == stall_iter && stall_left > 0) begin
                    if (!stalling) begin fx = e_x; fy = e_y; end
                    stalling = 1'b1;
                    d_valid = 1'b0;
                    stall_left--;
                end else begin
                    stalling = 1'b0;
                    obs_ex[iter] = val(e_x);
                    obs_ey[iter] = val(e_y);
                    d_valid = 1'b1; d_x = dx_q[iter]; d_y = dy_q[iter];
                    iter++;
                end
            end else begin
                stalling = 1'b0;
                d_valid = 1'b1; d_x = 2'($urandom); d_y = 2'($urandom);
            end
        end
        start = 1'b0;
        d_valid = 1'b0;
        if (lat < 0) timeout = 1'b1;
        ox = e_x; oy = e_y; oovf = ovf;
        @(negedge clk);
        if (done !== 1'b0 || ready !== 1'b1) pulse_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1)   begin n_errors++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (d_ready !== 1'b0) begin n_errors++; $display("FAIL reset_d_ready got %b want 0", d_ready); end
        n_checks++; if (done !== 1'b0)    begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (ovf !== 1'b0)     begin n_errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_checks++; if (e_x !== 16'h0 || e_y !== 16'h0) begin
            n_errors++; $display("FAIL reset_e got %h/%h want 0/0", e_x, e_y);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_digits();
        logic [15:0] ox, oy; logic oovf; int lat; bit fz, pk, to;
        for (int i = 0; i < N; i++) begin dx_q[i] = 2'b00; dy_q[i] = 2'b00; end
        run_op(enc(16), enc(0), -1, 0, 1'b0, ox, oy, oovf, lat, fz, pk, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL zero_timeout got no done want done"); end
        n_checks++; if (val(ox) != 16 || val(oy) != 0) begin
            n_errors++; $display("FAIL zero_e got %0d/%0d want 16/0", val(ox), val(oy));
        end
        n_checks++; if (lat != (SKIP ? 4 : 7)) begin
            n_errors++; $display("FAIL zero_latency got %0d want %0d", lat, SKIP ? 4 : 7);
        end
        n_checks++; if (oovf !== 1'b0) begin n_errors++; $display("FAIL zero_ovf got %b want 0", oovf); end
        n_checks++; if (!pk) begin n_errors++; $display("FAIL zero_done_pulse got wide pulse want one cycle"); end
    endtask

    task automatic test_dx_only();
        logic [15:0] ox, oy; logic oovf; int lat; bit fz, pk, to;
        for (int i = 0; i < N; i++) begin dx_q[i] = 2'b01; dy_q[i] = 2'b00; end
        run_op(enc(16), enc(0), -1, 0, 1'b0, ox, oy, oovf, lat, fz, pk, to);
        n_checks++; if (obs_ex[1] != 32 || obs_ex[2] != 48) begin
            n_errors++; $display("FAIL dx_steps got %0d,%0d want 32,48", obs_ex[1], obs_ex[2]);
        end
        n_checks++; if (to || val(ox) != 60 || val(oy) != 0 || oovf !== 1'b0) begin
            n_errors++; $display("FAIL dx_final got %0d/%0d ovf %b want 60/0 ovf 0", val(ox), val(oy), oovf);
        end
        n_checks++; if (lat != (SKIP ? 4 : 7)) begin
            n_errors++; $display("FAIL dx_latency got %0d want %0d", lat, SKIP ? 4 : 7);
        end
    endtask

    task automatic test_rotate();
        logic [15:0] ox, oy; logic oovf; int lat; bit fz, pk, to;
        dx_q[0] = 2'b00; dy_q[0] = 2'b01;
        dx_q[1] = 2'b00; dy_q[1] = 2'b11;
        dx_q[2] = 2'b00; dy_q[2] = 2'b00;
        run_op(enc(16), enc(0), -1, 0, 1'b0, ox, oy, oovf, lat, fz, pk, to);
        n_checks++; if (obs_ex[1] != 16 || obs_ey[1] != 16) begin
            n_errors++; $display("FAIL rot_n0 got %0d/%0d want 16/16", obs_ex[1], obs_ey[1]);
        end
        n_checks++; if (to || val(ox) != 24 || val(oy) != 8) begin
            n_errors++; $display("FAIL rot_final got %0d/%0d want 24/8", val(ox), val(oy));
        end
    endtask

    task automatic test_stall();
        logic [15:0] ax, ay, bx, by; logic aovf, bovf; int alat, blat; bit fz, pk, to, to2;
        int mx, my, ml; bit mo;
        dx_q[0] = 2'b01; dy_q[0] = 2'b01;
        dx_q[1] = 2'b11; dy_q[1] = 2'b11;
        dx_q[2] = 2'b10; dy_q[2] = 2'b01;
        model(20, -12, mx, my, mo, ml);
        run_op(enc(20), enc(-12), -1, 0, 1'b0, ax, ay, aovf, alat, fz, pk, to);
        run_op(enc(20), enc(-12), 1, 5, 1'b0, bx, by, bovf, blat, fz, pk, to2);
        n_checks++; if (to || val(ax) != mx || val(ay) != my) begin
            n_errors++; $display("FAIL stall_ref got %0d/%0d want %0d/%0d", val(ax), val(ay), mx, my);
        end
        n_checks++; if (to2 || val(bx) != mx || val(by) != my || bovf !== mo) begin
            n_errors++; $display("FAIL stall_e got %0d/%0d ovf %b want %0d/%0d ovf %b", val(bx), val(by), bovf, mx, my, mo);
        end
        n_checks++; if (blat != ml + 5) begin
            n_errors++; $display("FAIL stall_latency got %0d want %0d", blat, ml + 5);
        end
        n_checks++; if (!fz) begin n_errors++; $display("FAIL stall_frozen got changing E want held E"); end
    endtask

    task automatic test_overflow();
        logic [15:0] ox, oy; logic oovf; int lat; bit fz, pk, to;
        int mx, my, ml; bit mo;
        dx_q[0] = 2'b01; dy_q[0] = 2'b00;
        dx_q[1] = 2'b00; dy_q[1] = 2'b00;
        dx_q[2] = 2'b00; dy_q[2] = 2'b00;
        model(192, 0, mx, my, mo, ml);
        run_op(enc(192), enc(0), -1, 0, 1'b1, ox, oy, oovf, lat, fz, pk, to);
        n_checks++; if (to || oovf !== 1'b1) begin
            n_errors++; $display("FAIL ovf_set got %b want 1", oovf);
        end
        n_checks++; if (val(ox) != mx || val(oy) != my || lat != ml) begin
            n_errors++; $display("FAIL ovf_busy_start got %0d/%0d lat %0d want %0d/%0d lat %0d",
                                 val(ox), val(oy), lat, mx, my, ml);
        end
        repeat (3) @(negedge clk);
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        for (int i = 0; i < N; i++) begin dx_q[i] = 2'b00; dy_q[i] = 2'b00; end
        run_op(enc(5), enc(-3), -1, 0, 1'b0, ox, oy, oovf, lat, fz, pk, to);
        n_checks++; if (to || oovf !== 1'b0 || val(ox) != 5 || val(oy) != -3) begin
            n_errors++; $display("FAIL ovf_clear got %b %0d/%0d want 0 5/-3", oovf, val(ox), val(oy));
        end
    endtask

    task automatic test_rst_abort();
        int  xfers = 0;
        bit  found = 1'b0;
        int  dones = 0;
        start = 1'b1; e0_x = enc(192); e0_y = enc(0);
        d_valid = 1'b1; d_x = 2'b01; d_y = 2'b01;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (d_ready) xfers++;
            else if (xfers == 2) begin found = 1'b1; break; end
        end
        n_checks++; if (!found || ovf !== 1'b1) begin
            n_errors++; $display("FAIL abort_setup got phb %0d ovf %b want 1 1", found, ovf);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_valid = 1'b0;
        n_checks++; if (ready !== 1'b1 || e_x !== 16'h0 || e_y !== 16'h0 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL abort_state got rdy %b e %h/%h ovf %b want 1 0/0 0", ready, e_x, e_y, ovf);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++; if (dones != 0) begin n_errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
    endtask

    task automatic test_random();
        logic [15:0] ix, iy, ox, oy; logic oovf; int lat; bit fz, pk, to;
        int mx, my, ml; bit mo;
        for (int r = 0; r < 12; r++) begin
            ix = rand_csd(); iy = rand_csd();
            for (int i = 0; i < N; i++) begin
                dx_q[i] = 2'($urandom_range(0, 3));
                dy_q[i] = 2'($urandom_range(0, 3));
            end
            model(val(ix), val(iy), mx, my, mo, ml);
            run_op(ix, iy, -1, 0, 1'b0, ox, oy, oovf, lat, fz, pk, to);
            n_checks++; if (to || val(ox) != mx || val(oy) != my || oovf !== mo || lat != ml) begin
                n_errors++;
                $display("FAIL random_%0d got %0d/%0d ovf %b lat %0d want %0d/%0d ovf %b lat %0d",
                         r, val(ox), val(oy), oovf, lat, mx, my, mo, ml);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_digits();
        test_dx_only();
        test_rotate();
        test_stall();
        test_overflow();
        test_rst_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
